// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the core sequencer: opcode and funct codes,
// ALU operation encodings and the sequencer state enum.
package core_ctrl_pkg;

  localparam int INSTR_W = 32;

  // Major opcodes the core understands
  localparam logic [6:0] R_TYPE   = 7'b0110011;
  localparam logic [6:0] I_FORMAT = 7'b0010011;

  // R-type {funct7, funct3} combinations
  localparam logic [9:0] F73_ADD = 10'b0000000_000;
  localparam logic [9:0] F73_SUB = 10'b0100000_000;
  localparam logic [9:0] F73_OR  = 10'b0000000_110;
  localparam logic [9:0] F73_AND = 10'b0000000_111;

  // I-format funct3 codes (funct7 is part of the immediate there)
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_INV = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-memory req/ack port. The core drives req/addr through the
// master modport; the memory answers with ack/rdata through the slave modport.
interface core_seq_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int PC_W = 32
);

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/core_seq_ctrl_alu_decode.sv
// Combinational instruction decoder: maps opcode/funct fields to the ALU
// operation, the operand-B select and a legality flag. Anything not in the
// supported set comes back as illegal with the invalid ALU code.
module core_alu_decode
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       legal
);

  logic [9:0] f73;
  assign f73 = {funct7, funct3};

  // Decode table; defaults describe an unsupported instruction
  always_comb begin
    alu_op      = ALU_INV;
    alu_src_imm = 1'b0;
    legal       = 1'b0;
    case (opcode)
      R_TYPE: begin
        case (f73)
          F73_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
          F73_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
          F73_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
          F73_AND: begin alu_op = ALU_AND; legal = 1'b1; end
          default: ;
        endcase
      end
      I_FORMAT: begin
        case (funct3)
          F3_ADD: begin alu_op = ALU_ADD; alu_src_imm = 1'b1; legal = 1'b1; end
          F3_OR:  begin alu_op = ALU_OR;  alu_src_imm = 1'b1; legal = 1'b1; end
          F3_AND: begin alu_op = ALU_AND; alu_src_imm = 1'b1; legal = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue integer core. Owns the PC,
// fetches one instruction at a time, latches it into ir, decodes it and
// pulses reg_wen once per retired instruction that writes a register.
// Optional feature: define CORE_SEQ_INSTRET_EN to add the 32-bit instret
// retired-instruction counter port.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  core_seq_ctrl_if.master    imem,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         alu_op,
  output logic               alu_src_imm,
  output logic               reg_wen,
  output logic               illegal,
  output logic               busy
`ifdef CORE_SEQ_INSTRET_EN
  ,
  output logic [31:0]        instret
`endif
);

  state_e     state;
  logic [3:0] dec_op;
  logic       dec_imm;
  logic       dec_legal;

  assign imem.addr = pc;

  core_alu_decode u_decode (
    .opcode      (ir[6:0]),
    .funct3      (ir[14:12]),
    .funct7      (ir[31:25]),
    .alu_op      (dec_op),
    .alu_src_imm (dec_imm),
    .legal       (dec_legal)
  );

  // Sequencer FSM with all control outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      alu_op      <= ALU_INV;
      alu_src_imm <= 1'b0;
      imem.req    <= 1'b0;
      reg_wen     <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem.req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem.ack) begin
            ir       <= imem.rdata;
            imem.req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            alu_op      <= dec_op;
            alu_src_imm <= dec_imm;
            state       <= EXEC;
          end else begin
            alu_op      <= ALU_INV;
            alu_src_imm <= 1'b0;
            illegal     <= 1'b1;
            busy        <= 1'b0;
            state       <= HALT;
          end
        end
        EXEC: begin
          reg_wen <= (ir[11:7] != 5'd0);
          state   <= WB;
        end
        WB: begin
          pc <= pc + PC_W'(4);
          if (run) begin
            state    <= FETCH;
            imem.req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORE_SEQ_INSTRET_EN
  // Count every WB cycle, including instructions whose rd is x0
  always_ff @(posedge clk) begin
    if (rst)
      instret <= '0;
    else if (state == WB)
      instret <= instret + 32'd1;
  end
`endif

endmodule
